// File: rtl/motor_drv_mc.sv
// rtl/motor_drv_mc.sv - multi-channel H-bridge PWM driver with dead time and brake
// Optional duty ramping when MOTOR_DRV_RAMP_EN is defined.
`timescale 1ns/1ps
module motor_drv_mc #(
  parameter int CLK_HZ       = 25000000,
  parameter int PWM_HZ       = 250,
  parameter int CHANNELS     = 2,
  parameter int RES_BITS     = 8,
  parameter int DEAD_PERIODS = 1,
  parameter int RAMP_STEP    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [CHANNELS*RES_BITS-1:0] duty,
  input  logic [CHANNELS-1:0]          direction,
  input  logic [CHANNELS-1:0]          brake,
  output logic [CHANNELS-1:0]          pwm_outA,
  output logic [CHANNELS-1:0]          pwm_outB,
  output logic [CHANNELS-1:0]          busy,
  output logic                         period_start
);

  localparam int PRESCALE = CLK_HZ / (PWM_HZ * (2**RES_BITS));
  localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DC_W     = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;

  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [DC_W-1:0] DEAD_LOAD = DC_W'(DEAD_PERIODS);

  localparam logic [1:0] S_COAST = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DEAD  = 2'd2;
  localparam logic [1:0] S_BRAKE = 2'd3;

  if (PRESCALE < 1 || CHANNELS < 1 || CHANNELS > 8 || RES_BITS < 2 || RES_BITS > 12 ||
      DEAD_PERIODS < 0 || RAMP_STEP < 0) begin : g_bad_param
    $error("motor_drv_mc: invalid parameter set");
  end

`ifdef MOTOR_DRV_RAMP_EN
  function automatic logic [RES_BITS-1:0] duty_step(input logic [RES_BITS-1:0] cur,
                                                   input logic [RES_BITS-1:0] tgt_v);
    int diff;
    diff = int'(tgt_v) - int'(cur);
    if (diff > RAMP_STEP)       return cur + RES_BITS'(RAMP_STEP);
    else if (diff < -RAMP_STEP) return cur - RES_BITS'(RAMP_STEP);
    else                        return tgt_v;
  endfunction
`else
  function automatic logic [RES_BITS-1:0] duty_step(input logic [RES_BITS-1:0] cur,
                                                   input logic [RES_BITS-1:0] tgt_v);
    return (cur == tgt_v) ? cur : tgt_v;
  endfunction
`endif

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [RES_BITS-1:0] pcnt_q, pcnt_d;
  logic                boundary;

  logic [1:0]          st_q    [CHANNELS];
  logic [1:0]          st_d    [CHANNELS];
  logic [RES_BITS-1:0] aduty_q [CHANNELS];
  logic [RES_BITS-1:0] aduty_d [CHANNELS];
  logic [DC_W-1:0]     dcnt_q  [CHANNELS];
  logic [DC_W-1:0]     dcnt_d  [CHANNELS];
  logic [CHANNELS-1:0] adir_q, adir_d;
  logic [CHANNELS-1:0] outa_d, outb_d, busy_d;
  logic [RES_BITS-1:0] tgt;
  logic                pwm;

  always_comb begin
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    if (!enable) begin
      presc_d = '0;
      pcnt_d  = '0;
    end else if (presc_q == PS_LAST) begin
      presc_d = '0;
      pcnt_d  = pcnt_q + RES_BITS'(1);
    end else begin
      presc_d = presc_q + PS_W'(1);
    end
  end

  assign boundary = enable && (presc_q == '0) && (pcnt_q == '0);

  // Outputs are computed from next state so a boundary command shows up one clock later.
  always_comb begin
    tgt    = '0;
    pwm    = 1'b0;
    adir_d = adir_q;
    outa_d = '0;
    outb_d = '0;
    busy_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      st_d[c]    = st_q[c];
      aduty_d[c] = aduty_q[c];
      dcnt_d[c]  = dcnt_q[c];
      tgt        = duty[c*RES_BITS +: RES_BITS];
      if (!enable) begin
        st_d[c]    = S_COAST;
        aduty_d[c] = '0;
        dcnt_d[c]  = '0;
      end else if (boundary) begin
        case (st_q[c])
          S_COAST, S_BRAKE: begin
            if (brake[c]) begin
              st_d[c]    = S_BRAKE;
              aduty_d[c] = '0;
            end else begin
              st_d[c]    = S_RUN;
              adir_d[c]  = direction[c];
              aduty_d[c] = duty_step('0, tgt);
            end
          end
          S_RUN: begin
            if (brake[c]) begin
              st_d[c]    = S_BRAKE;
              aduty_d[c] = '0;
            end else if ((direction[c] != adir_q[c]) && (DEAD_PERIODS > 0)) begin
              st_d[c]    = S_DEAD;
              dcnt_d[c]  = DEAD_LOAD;
              aduty_d[c] = '0;
            end else begin
              adir_d[c]  = direction[c];
              aduty_d[c] = duty_step(aduty_q[c], tgt);
            end
          end
          S_DEAD: begin
            if (brake[c]) begin
              st_d[c]    = S_BRAKE;
              dcnt_d[c]  = '0;
            end else if (dcnt_q[c] <= DC_W'(1)) begin
              st_d[c]    = S_RUN;
              dcnt_d[c]  = '0;
              adir_d[c]  = direction[c];
              aduty_d[c] = duty_step('0, tgt);
            end else begin
              dcnt_d[c]  = dcnt_q[c] - DC_W'(1);
            end
          end
          default: st_d[c] = S_COAST;
        endcase
      end
      pwm = pcnt_q < aduty_d[c];
      case (st_d[c])
        S_RUN: begin
          outa_d[c] = adir_d[c] & pwm;
          outb_d[c] = ~adir_d[c] & pwm;
        end
        S_BRAKE: begin
          outa_d[c] = 1'b1;
          outb_d[c] = 1'b1;
        end
        default: begin
          outa_d[c] = 1'b0;
          outb_d[c] = 1'b0;
        end
      endcase
      busy_d[c] = (st_d[c] == S_DEAD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      pcnt_q       <= '0;
      adir_q       <= '0;
      pwm_outA     <= '0;
      pwm_outB     <= '0;
      busy         <= '0;
      period_start <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        st_q[c]    <= S_COAST;
        aduty_q[c] <= '0;
        dcnt_q[c]  <= '0;
      end
    end else begin
      presc_q      <= presc_d;
      pcnt_q       <= pcnt_d;
      adir_q       <= adir_d;
      pwm_outA     <= outa_d;
      pwm_outB     <= outb_d;
      busy         <= busy_d;
      period_start <= boundary;
      for (int c = 0; c < CHANNELS; c++) begin
        st_q[c]    <= st_d[c];
        aduty_q[c] <= aduty_d[c];
        dcnt_q[c]  <= dcnt_d[c];
      end
    end
  end

endmodule
